// File: rtl/ram_capture.sv
// ram_capture -- triggered / one-shot sample capture buffer on a simple dual-port RAM.
//
// Captures a stream of samples into a 2^NB_ADDR-word buffer in one of two modes:
//   mode 0 (one-shot): fill the buffer once from address 0, then stop.
//   mode 1 (triggered): write circularly until a trigger, then write in_post_count
//                       more samples and stop. out_start_addr then points at the
//                       oldest sample so logical read address 0 is the oldest word.
//
// Optional feature macro: RAM_CAPTURE_DECIM_EN
//   defined   -> only every (in_decim+1)th valid sample is accepted.
//   undefined -> every valid sample is accepted; in_decim is ignored.
//
// Ports:
//   clock           system clock, all logic on the rising edge
//   cpu_reset       synchronous active-high reset
//   in_run          capture enable; deassertion aborts a capture or releases DONE
//   in_mode         0 = one-shot fill, 1 = triggered circular (sampled in IDLE only)
//   in_trigger      trigger pulse, honoured only while armed
//   in_post_count   number of samples written after the trigger sample
//   in_decim        decimation ratio minus one
//   in_data         input sample
//   ctrl_valid      in_data is valid this cycle
//   in_read_addr    logical read address, 0 = oldest sample
//   out_data        read data, two edges after in_read_addr is sampled
//   out_full        capture complete
//   out_busy        capture in progress (FILL, ARM or POST)
//   out_start_addr  physical address of the oldest sample

module ram_capture #(
    parameter int unsigned NB_ADDR  = 11,
    parameter int unsigned NB_DATA  = 16,
    parameter int unsigned NB_DECIM = 8
) (
    input  logic                clock,
    input  logic                cpu_reset,
    input  logic                in_run,
    input  logic                in_mode,
    input  logic                in_trigger,
    input  logic [NB_ADDR-1:0]  in_post_count,
    input  logic [NB_DECIM-1:0] in_decim,
    input  logic [NB_DATA-1:0]  in_data,
    input  logic                ctrl_valid,
    input  logic [NB_ADDR-1:0]  in_read_addr,
    output logic [NB_DATA-1:0]  out_data,
    output logic                out_full,
    output logic                out_busy,
    output logic [NB_ADDR-1:0]  out_start_addr
);

    localparam int unsigned       Depth    = 2 ** NB_ADDR;
    localparam logic [NB_ADDR-1:0] AddrMax = '1;
    localparam logic [NB_ADDR-1:0] AddrOne = NB_ADDR'(1);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StArm,
        StPost,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic               wrapped_q, wrapped_d;
    logic [NB_ADDR-1:0] remain_q, remain_d;
    logic [NB_ADDR-1:0] start_q, start_d;
    logic               full_q, full_d;
    logic               busy_q, busy_d;

    logic               capturing;
    logic               strobe;
    logic               accept;
    logic               wr_en;

    // ------------------------------------------------------------------
    // Decimation strobe
    // ------------------------------------------------------------------
`ifdef RAM_CAPTURE_DECIM_EN
    logic [NB_DECIM-1:0] decim_q, decim_d;

    // Counter is zero on the first valid after FILL/ARM entry, so that
    // sample is always taken; afterwards every (in_decim+1)th valid.
    assign strobe = (decim_q == '0);

    always_comb begin
        decim_d = decim_q;
        if (state_q == StIdle && in_run) begin
            decim_d = '0;
        end else if (capturing && ctrl_valid) begin
            if (decim_q >= in_decim) begin
                decim_d = '0;
            end else begin
                decim_d = decim_q + NB_DECIM'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (cpu_reset) begin
            decim_q <= '0;
        end else begin
            decim_q <= decim_d;
        end
    end
`else
    logic unused_decim;
    assign unused_decim = ^in_decim;
    assign strobe       = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Control FSM: next-state and datapath updates
    // ------------------------------------------------------------------
    assign capturing = (state_q == StFill) || (state_q == StArm) || (state_q == StPost);
    assign accept    = capturing && ctrl_valid && strobe;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        wrapped_d = wrapped_q;
        remain_d  = remain_q;
        start_d   = start_q;
        wr_en     = 1'b0;

        if (accept) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AddrOne;
            if (wr_ptr_q == AddrMax) begin
                wrapped_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (in_run) begin
                    state_d   = in_mode ? StArm : StFill;
                    wr_ptr_d  = '0;
                    wrapped_d = 1'b0;
                    remain_d  = '0;
                    start_d   = '0;
                end
            end

            StFill: begin
                if (!in_run) begin
                    state_d = StIdle;
                end else if (accept && wr_ptr_q == AddrMax) begin
                    state_d = StDone;
                    start_d = '0;
                end
            end

            StArm: begin
                if (!in_run) begin
                    state_d = StIdle;
                end else if (in_trigger) begin
                    remain_d = in_post_count;
                    if (in_post_count == '0) begin
                        // The trigger sample (if any) is the last write; use the
                        // pointer/wrap state that includes it.
                        state_d = StDone;
                        start_d = wrapped_d ? wr_ptr_d : '0;
                    end else begin
                        state_d = StPost;
                    end
                end
            end

            StPost: begin
                if (!in_run) begin
                    state_d = StIdle;
                end else if (accept) begin
                    remain_d = remain_q - AddrOne;
                    if (remain_q == AddrOne) begin
                        state_d = StDone;
                        start_d = wrapped_d ? wr_ptr_d : '0;
                    end
                end
            end

            StDone: begin
                if (!in_run) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Status flags follow the next state so they move on the same edge.
        full_d = (state_d == StDone);
        busy_d = (state_d == StFill) || (state_d == StArm) || (state_d == StPost);
    end

    always_ff @(posedge clock) begin
        if (cpu_reset) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            wrapped_q <= 1'b0;
            remain_q  <= '0;
            start_q   <= '0;
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            wrapped_q <= wrapped_d;
            remain_q  <= remain_d;
            start_q   <= start_d;
            full_q    <= full_d;
            busy_q    <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Sample memory: simple dual-port, write-port / read-port separate.
    // Contents are deliberately not reset so it maps onto block RAM.
    // ------------------------------------------------------------------
    logic [NB_DATA-1:0] mem [Depth];
    logic [NB_ADDR-1:0] rd_addr_q;
    logic [NB_DATA-1:0] rd_data_q;

    always_ff @(posedge clock) begin
        if (wr_en && !cpu_reset) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // Two-stage read: registered physical address, then registered RAM output.
    // A read colliding with a write returns the old word.
    always_ff @(posedge clock) begin
        if (cpu_reset) begin
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_addr_q <= start_q + in_read_addr;
            rd_data_q <= mem[rd_addr_q];
        end
    end

    assign out_data       = rd_data_q;
    assign out_full       = full_q;
    assign out_busy       = busy_q;
    assign out_start_addr = start_q;

endmodule

// File: tb/tb_ram_capture.sv
// Directed bench for ram_capture with NB_ADDR=4 (16-word buffer), NB_DATA=8.

module tb_ram_capture;

    localparam int unsigned NB_ADDR  = 4;
    localparam int unsigned NB_DATA  = 8;
    localparam int unsigned NB_DECIM = 8;

    logic                clock = 1'b0;
    logic                cpu_reset;
    logic                in_run;
    logic                in_mode;
    logic                in_trigger;
    logic [NB_ADDR-1:0]  in_post_count;
    logic [NB_DECIM-1:0] in_decim;
    logic [NB_DATA-1:0]  in_data;
    logic                ctrl_valid;
    logic [NB_ADDR-1:0]  in_read_addr;
    logic [NB_DATA-1:0]  out_data;
    logic                out_full;
    logic                out_busy;
    logic [NB_ADDR-1:0]  out_start_addr;

    int vectors    = 0;
    int miscompares = 0;

    ram_capture #(
        .NB_ADDR  (NB_ADDR),
        .NB_DATA  (NB_DATA),
        .NB_DECIM (NB_DECIM)
    ) dut (
        .clock          (clock),
        .cpu_reset      (cpu_reset),
        .in_run         (in_run),
        .in_mode        (in_mode),
        .in_trigger     (in_trigger),
        .in_post_count  (in_post_count),
        .in_decim       (in_decim),
        .in_data        (in_data),
        .ctrl_valid     (ctrl_valid),
        .in_read_addr   (in_read_addr),
        .out_data       (out_data),
        .out_full       (out_full),
        .out_busy       (out_busy),
        .out_start_addr (out_start_addr)
    );

    always #5 clock = ~clock;

    // Advance one rising edge; inputs are then changed and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic read_check(input string tag, input logic [NB_ADDR-1:0] addr,
                              input logic [31:0] expected);
        in_read_addr = addr;
        tick();
        tick();
        check(tag, 32'(out_data), expected);
    endtask

    task automatic release_run();
        in_run     = 1'b0;
        ctrl_valid = 1'b0;
        in_trigger = 1'b0;
        tick();
    endtask

    initial begin
        cpu_reset     = 1'b1;
        in_run        = 1'b1;
        in_mode       = 1'b0;
        in_trigger    = 1'b0;
        in_post_count = '0;
        in_decim      = '0;
        in_data       = 8'hAA;
        ctrl_valid    = 1'b1;
        in_read_addr  = '0;

        // Reset wins over run/valid.
        tick();
        tick();
        tick();
        check("rst_full", 32'(out_full), 0);
        check("rst_busy", 32'(out_busy), 0);
        check("rst_start", 32'(out_start_addr), 0);
        check("rst_data", 32'(out_data), 0);
        cpu_reset  = 1'b0;
        in_run     = 1'b0;
        ctrl_valid = 1'b0;
        tick();

        // One-shot: data 0..16, 16 must be ignored; stray trigger ignored.
        in_mode = 1'b0;
        in_run  = 1'b1;
        tick();
        check("fill_busy", 32'(out_busy), 1);
        check("fill_full0", 32'(out_full), 0);
        in_mode = 1'b1;  // must not matter outside IDLE
        for (int i = 0; i <= 16; i++) begin
            in_data    = 8'(i);
            ctrl_valid = 1'b1;
            in_trigger = (i == 8);
            tick();
            if (i == 14) check("fill_notfull", 32'(out_full), 0);
            if (i == 15) begin
                check("fill_full", 32'(out_full), 1);
                check("fill_idle_busy", 32'(out_busy), 0);
            end
        end
        ctrl_valid = 1'b0;
        in_trigger = 1'b0;
        check("fill_start", 32'(out_start_addr), 0);
        read_check("fill_rd5", 4'd5, 5);
        read_check("fill_rd0", 4'd0, 0);
        read_check("fill_rd15", 4'd15, 15);
        release_run();
        check("fill_release", 32'(out_full), 0);

        // Triggered wrap: data 0..39, trigger at 30, post 5 -> last write 35.
        in_mode       = 1'b1;
        in_post_count = 4'd5;
        in_run        = 1'b1;
        tick();
        for (int i = 0; i <= 39; i++) begin
            in_data    = 8'(i);
            ctrl_valid = 1'b1;
            in_trigger = (i == 30);
            tick();
            if (i == 10) check("arm_busy", 32'(out_busy), 1);
            if (i == 34) check("post_notfull", 32'(out_full), 0);
            if (i == 35) check("wrap_full", 32'(out_full), 1);
        end
        ctrl_valid = 1'b0;
        in_trigger = 1'b0;
        check("wrap_start", 32'(out_start_addr), 4);
        read_check("wrap_rd0", 4'd0, 20);
        read_check("wrap_rd15", 4'd15, 35);
        read_check("wrap_rd11", 4'd11, 31);
        release_run();

        // Early trigger: trigger at 3, post 2 -> writes 0..5, no wrap.
        in_post_count = 4'd2;
        in_run        = 1'b1;
        tick();
        for (int i = 0; i <= 9; i++) begin
            in_data    = 8'(i);
            ctrl_valid = 1'b1;
            in_trigger = (i == 3);
            tick();
            if (i == 5) check("early_full", 32'(out_full), 1);
        end
        ctrl_valid = 1'b0;
        in_trigger = 1'b0;
        check("early_start", 32'(out_start_addr), 0);
        read_check("early_rd0", 4'd0, 0);
        read_check("early_rd4", 4'd4, 4);
        read_check("early_rd5", 4'd5, 5);
        release_run();

        // Post count 0: trigger at 20 -> DONE on that edge, newest = 20.
        in_post_count = 4'd0;
        in_run        = 1'b1;
        tick();
        for (int i = 0; i <= 24; i++) begin
            in_data    = 8'(i);
            ctrl_valid = 1'b1;
            in_trigger = (i == 20);
            tick();
            if (i == 20) check("post0_full", 32'(out_full), 1);
        end
        ctrl_valid = 1'b0;
        in_trigger = 1'b0;
        check("post0_start", 32'(out_start_addr), 5);
        read_check("post0_rd14", 4'd14, 19);
        read_check("post0_rd15", 4'd15, 20);

        // Reset while DONE with run still high: everything returns to zero.
        cpu_reset  = 1'b1;
        ctrl_valid = 1'b1;
        tick();
        check("rst2_full", 32'(out_full), 0);
        check("rst2_busy", 32'(out_busy), 0);
        check("rst2_start", 32'(out_start_addr), 0);
        check("rst2_data", 32'(out_data), 0);
        tick();
        check("rst2_busy_hold", 32'(out_busy), 0);
        cpu_reset = 1'b0;
        release_run();

        // Abort mid-POST.
        in_mode       = 1'b1;
        in_post_count = 4'd10;
        in_run        = 1'b1;
        tick();
        for (int i = 0; i <= 5; i++) begin
            in_data    = 8'(i);
            ctrl_valid = 1'b1;
            in_trigger = (i == 2);
            tick();
        end
        check("post_busy", 32'(out_busy), 1);
        in_run = 1'b0;
        tick();
        check("abort_full", 32'(out_full), 0);
        check("abort_busy", 32'(out_busy), 0);
        ctrl_valid = 1'b0;
        in_trigger = 1'b0;
        tick();

`ifdef RAM_CAPTURE_DECIM_EN
        // Decimate by 3: accepted 0,3,...,45.
        in_decim = 8'd2;
        in_mode  = 1'b0;
        in_run   = 1'b1;
        tick();
        for (int i = 0; i <= 47; i++) begin
            in_data    = 8'(i);
            ctrl_valid = 1'b1;
            tick();
            if (i == 44) check("dec_notfull", 32'(out_full), 0);
            if (i == 45) check("dec_full", 32'(out_full), 1);
        end
        ctrl_valid = 1'b0;
        read_check("dec_rd0", 4'd0, 0);
        read_check("dec_rd5", 4'd5, 15);
        read_check("dec_rd15", 4'd15, 45);
        release_run();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
